// File: rtl/johnson_monitor_if.sv
// Sample/status bundle between a Johnson-code source and johnson_monitor.
// The err_cnt signal exists only when JMON_ERRCNT_EN is defined.
interface johnson_monitor_if #(
  parameter int unsigned ERR_W = 8
) ();

  logic       en;
  logic [3:0] johnson_in;
  logic [2:0] phase;
  logic       phase_vld;
  logic       locked;
  logic       seq_err;
  logic [7:0] lap_cnt;
`ifdef JMON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;
`endif

  // A zero-width error counter cannot be built.
  if (ERR_W < 1) begin : g_err_w_chk
    $error("johnson_monitor_if: ERR_W must be at least 1");
  end

  // The source side drives samples and observes the status.
  modport master (
    output en, johnson_in,
    input  phase, phase_vld, locked, seq_err, lap_cnt
`ifdef JMON_ERRCNT_EN
    , input err_cnt
`endif
  );

  // The monitor side consumes samples and drives the status.
  modport slave (
    input  en, johnson_in,
    output phase, phase_vld, locked, seq_err, lap_cnt
`ifdef JMON_ERRCNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/johnson_monitor.sv
// Johnson-counter sequence monitor. It decodes 4-bit Johnson samples into
// phases, acquires lock after LOCK_CNT consecutive successors, flags
// sequence violations while locked, and counts completed laps.
// Optional feature macro: JMON_ERRCNT_EN adds a saturating err_cnt counter.
module johnson_monitor #(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input logic              clk,
  input logic              rst,
  johnson_monitor_if.slave bus
);

  localparam int unsigned PH_W  = 3;
  localparam int unsigned GC_W  = 4;
  localparam int unsigned LAP_W = 8;
  localparam logic [GC_W-1:0] LOCK_TGT = GC_W'(LOCK_CNT);
  localparam logic [PH_W-1:0] LAST_PH  = PH_W'(7);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // The lock threshold must fit the good-sample counter and be non-zero.
  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_lock_cnt_chk
    $error("johnson_monitor: LOCK_CNT must be in 1..15");
  end
  if (ERR_W < 1) begin : g_err_w_chk
    $error("johnson_monitor: ERR_W must be at least 1");
  end

  state_t           state;
  logic [GC_W-1:0]  good_cnt;
  logic [PH_W-1:0]  phase_q;
  logic             phase_vld_q;
  logic             locked_q;
  logic             seq_err_q;
  logic [LAP_W-1:0] lap_cnt_q;

  logic             dec_legal;
  logic [PH_W-1:0]  dec_phase;
  logic             is_succ;
  logic             lap_wrap;
  logic             lock_viol;
  logic [GC_W-1:0]  good_nxt;

  // Map the eight legal Johnson codes to phases 0..7; all others are illegal.
  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    case (bus.johnson_in)
      4'b0000: begin dec_legal = 1'b1; dec_phase = PH_W'(0); end
      4'b0001: begin dec_legal = 1'b1; dec_phase = PH_W'(1); end
      4'b0011: begin dec_legal = 1'b1; dec_phase = PH_W'(2); end
      4'b0111: begin dec_legal = 1'b1; dec_phase = PH_W'(3); end
      4'b1111: begin dec_legal = 1'b1; dec_phase = PH_W'(4); end
      4'b1110: begin dec_legal = 1'b1; dec_phase = PH_W'(5); end
      4'b1100: begin dec_legal = 1'b1; dec_phase = PH_W'(6); end
      4'b1000: begin dec_legal = 1'b1; dec_phase = PH_W'(7); end
      default: begin dec_legal = 1'b0; dec_phase = '0; end
    endcase
  end

  // Successor test against the stored phase, plus lap and violation qualifiers.
  always_comb begin
    is_succ   = dec_legal && (dec_phase == (phase_q + PH_W'(1)));
    lap_wrap  = is_succ && (phase_q == LAST_PH);
    lock_viol = bus.en && (state == LOCKED) && !is_succ;
    good_nxt  = good_cnt + GC_W'(1);
  end

  // Lock-tracking FSM with registered outputs; en=0 freezes everything but the pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= UNLOCKED;
      good_cnt    <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      lap_cnt_q   <= '0;
    end else begin
      phase_vld_q <= 1'b0;
      seq_err_q   <= 1'b0;
      if (bus.en) begin
        if (dec_legal) begin
          phase_q     <= dec_phase;
          phase_vld_q <= 1'b1;
        end
        case (state)
          UNLOCKED: begin
            if (dec_legal) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (!dec_legal) begin
              state    <= UNLOCKED;
              good_cnt <= '0;
            end else if (is_succ) begin
              if (good_nxt == LOCK_TGT) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_nxt;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!dec_legal) begin
              state     <= UNLOCKED;
              locked_q  <= 1'b0;
              seq_err_q <= 1'b1;
              good_cnt  <= '0;
            end else if (!is_succ) begin
              state     <= ACQUIRE;
              locked_q  <= 1'b0;
              seq_err_q <= 1'b1;
              good_cnt  <= '0;
            end else if (lap_wrap) begin
              lap_cnt_q <= lap_cnt_q + LAP_W'(1);
            end
          end
          default: begin
            state    <= UNLOCKED;
            locked_q <= 1'b0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.phase_vld = phase_vld_q;
  assign bus.locked    = locked_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.lap_cnt   = lap_cnt_q;

`ifdef JMON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating count of sequence violations seen while locked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (lock_viol && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed bench for johnson_monitor with a phase-level reference model.
module tb_johnson_monitor;

  localparam int unsigned ERR_W    = 2;
  localparam int unsigned LOCK_CNT = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   chk_on;

  // Reference model state: mode 0=unlocked, 1=acquiring, 2=locked.
  int m_mode;
  int m_phase;
  int m_good;
  int m_lap;
  int m_vld;
  int m_err;
  int m_errcnt;

  johnson_monitor_if #(.ERR_W(ERR_W)) bus ();

  johnson_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson code for a phase: fill ones from the LSB, then drain them from the LSB.
  function automatic logic [3:0] jcode(input int p);
    int v;
    if (p < 4) v = (1 << p) - 1;
    else       v = (15 << (p - 4)) & 15;
    return 4'(v);
  endfunction

  function automatic int jdecode(input logic [3:0] c);
    for (int p = 0; p < 8; p++) begin
      if (jcode(p) == c) return p;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_step(input bit r, input bit e, input logic [3:0] c);
    int  p;
    bit  succ;
    if (!r) begin
      m_mode = 0; m_phase = 0; m_good = 0; m_lap = 0;
      m_vld = 0; m_err = 0; m_errcnt = 0;
      return;
    end
    m_vld = 0;
    m_err = 0;
    if (!e) return;
    p    = jdecode(c);
    succ = (p >= 0) && (p == (m_phase + 1) % 8);
    if (p >= 0) m_vld = 1;
    if (m_mode == 0) begin
      if (p >= 0) begin m_mode = 1; m_good = 0; m_phase = p; end
    end else if (m_mode == 1) begin
      if (p < 0) begin
        m_mode = 0; m_good = 0;
      end else if (succ) begin
        m_good = m_good + 1;
        m_phase = p;
        if (m_good == LOCK_CNT) begin m_mode = 2; m_good = 0; end
      end else begin
        m_good = 0; m_phase = p;
      end
    end else begin
      if (p < 0) begin
        m_err = 1; m_mode = 0; m_good = 0;
      end else if (succ) begin
        if (m_phase == 7) m_lap = (m_lap + 1) % 256;
        m_phase = p;
      end else begin
        m_err = 1; m_mode = 1; m_good = 0; m_phase = p;
      end
    end
    if (m_err != 0 && m_errcnt < (1 << ERR_W) - 1) m_errcnt = m_errcnt + 1;
  endtask

  task automatic cyc(input bit r, input bit e, input logic [3:0] c);
    rst = r;
    bus.en = e;
    bus.johnson_in = c;
    @(posedge clk);
    model_step(r, e, c);
    chk_on = 1'b1;
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("phase",     32'(bus.phase),     32'(m_phase));
      chk("phase_vld", 32'(bus.phase_vld), 32'(m_vld));
      chk("locked",    32'(bus.locked),    32'(m_mode == 2));
      chk("seq_err",   32'(bus.seq_err),   32'(m_err));
      chk("lap_cnt",   32'(bus.lap_cnt),   32'(m_lap));
`ifdef JMON_ERRCNT_EN
      chk("err_cnt",   32'(bus.err_cnt),   32'(m_errcnt));
`endif
    end
  end

  initial begin
    int p;
    total = 0;
    bad = 0;
    chk_on = 1'b0;
    m_mode = 0; m_phase = 0; m_good = 0; m_lap = 0;
    m_vld = 0; m_err = 0; m_errcnt = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.johnson_in = 4'b0000;
    @(negedge clk);

    // Reset, including reset winning over a live sample.
    cyc(1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0011);
    chk("lit_rst_phase",  32'(bus.phase),     32'd0);
    chk("lit_rst_locked", 32'(bus.locked),    32'd0);
    chk("lit_rst_vld",    32'(bus.phase_vld), 32'd0);
    chk("lit_rst_lap",    32'(bus.lap_cnt),   32'd0);

    // Acquire and lock on 0000,0001,0011.
    cyc(1'b1, 1'b1, 4'b0000);
    chk("lit_acq0_vld", 32'(bus.phase_vld), 32'd1);
    cyc(1'b1, 1'b1, 4'b0001);
    chk("lit_acq1_locked", 32'(bus.locked), 32'd0);
    cyc(1'b1, 1'b1, 4'b0011);
    chk("lit_lock_locked", 32'(bus.locked), 32'd1);
    chk("lit_lock_phase",  32'(bus.phase),  32'd2);

    // Successor then a legal non-successor.
    cyc(1'b1, 1'b1, 4'b0111);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("lit_jump_seqerr", 32'(bus.seq_err), 32'd1);
    chk("lit_jump_locked", 32'(bus.locked),  32'd0);
    chk("lit_jump_phase",  32'(bus.phase),   32'd0);
`ifdef JMON_ERRCNT_EN
    chk("lit_jump_errcnt", 32'(bus.err_cnt), 32'd1);
`endif

    // Relock, then an illegal code while locked.
    cyc(1'b1, 1'b1, 4'b0001);
    chk("lit_acq_noerr", 32'(bus.seq_err), 32'd0);
    cyc(1'b1, 1'b1, 4'b0011);
    chk("lit_relock", 32'(bus.locked), 32'd1);
    cyc(1'b1, 1'b1, 4'b0101);
    chk("lit_ill_seqerr", 32'(bus.seq_err),   32'd1);
    chk("lit_ill_phase",  32'(bus.phase),     32'd2);
    chk("lit_ill_vld",    32'(bus.phase_vld), 32'd0);
    cyc(1'b1, 1'b1, 4'b1101);
    chk("lit_unl_silent", 32'(bus.seq_err), 32'd0);

    // Relock, then idle with garbage on the input.
    cyc(1'b1, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0001);
    cyc(1'b1, 1'b1, 4'b0011);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'(i * 3 + 5));
    chk("lit_idle_locked", 32'(bus.locked),    32'd1);
    chk("lit_idle_vld",    32'(bus.phase_vld), 32'd0);
    cyc(1'b1, 1'b1, 4'b0111);
    chk("lit_idle_resume", 32'(bus.locked),  32'd1);
    chk("lit_idle_phase",  32'(bus.phase),   32'd3);

    // Lock at phase 0, then count laps through the 8-bit wrap.
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b1100);
    cyc(1'b1, 1'b1, 4'b1000);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("lit_lock0_locked", 32'(bus.locked),  32'd1);
    chk("lit_lock0_lap",    32'(bus.lap_cnt), 32'd0);
    p = 0;
    for (int i = 0; i < 17; i++) begin
      p = (p + 1) % 8;
      cyc(1'b1, 1'b1, jcode(p));
    end
    chk("lit_lap2", 32'(bus.lap_cnt), 32'd2);
    for (int i = 0; i < 253 * 8; i++) begin
      p = (p + 1) % 8;
      cyc(1'b1, 1'b1, jcode(p));
    end
    chk("lit_lap255", 32'(bus.lap_cnt), 32'd255);
    for (int i = 0; i < 8; i++) begin
      p = (p + 1) % 8;
      cyc(1'b1, 1'b1, jcode(p));
    end
    chk("lit_lap_wrap",   32'(bus.lap_cnt), 32'd0);
    chk("lit_lap_locked", 32'(bus.locked),  32'd1);

    // Reset while locked, with a violating sample present.
    cyc(1'b0, 1'b1, 4'b0101);
    chk("lit_mid_rst_locked", 32'(bus.locked),  32'd0);
    chk("lit_mid_rst_seqerr", 32'(bus.seq_err), 32'd0);
    chk("lit_mid_rst_lap",    32'(bus.lap_cnt), 32'd0);

    // Five lock violations drive the 2-bit error counter into saturation.
    cyc(1'b1, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0001);
    cyc(1'b1, 1'b1, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 4'b0000);
      cyc(1'b1, 1'b1, 4'b0001);
      cyc(1'b1, 1'b1, 4'b0011);
    end
    chk("lit_sat_locked", 32'(bus.locked), 32'd1);
`ifdef JMON_ERRCNT_EN
    chk("lit_sat_errcnt", 32'(bus.err_cnt), 32'd3);
`endif

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
